// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM status types plus the memory arbiter state
// encoding and the load word returned when an access is abandoned.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC,
    RESP
  } arbstate_t;

  localparam word_t ARB_TIMEOUT_WORD = 32'hBAD0_BAD0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request-unit and RAM-side signal bundle for mem_arbiter.
// The arbiter connects through the slave modport; the requester/RAM side uses master.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // Handshake: a requester holds its REN/WEN strobe and operands steady until
  // the matching one-cycle hit; the strobe is sampled only while the arbiter is
  // idle, and the requester drops or changes it during the hit cycle. The RAM
  // completes an access by reporting ACCESS (or ERROR) on ramstate.
  logic  imemREN;
  word_t imemaddr;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  ihit;
  logic  dhit;
  word_t imemload;
  word_t dmemload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  ramstate_t ramstate;
  logic  arb_err;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, ramstate,
    output ihit, dhit, imemload, dmemload,
    output ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, ramstate,
    input  ihit, dhit, imemload, dmemload,
    input  ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requests onto one RAM port, data first.
// Optional watchdog on each RAM access is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus,
  output arbstate_t    arb_state
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arbstate_t state;
  logic  ihit_r, dhit_r, ramren_r, ramwen_r, err_r;
  word_t ramaddr_r, ramstore_r, iload_r, dload_r;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      ihit_r     <= 1'b0;
      dhit_r     <= 1'b0;
      ramren_r   <= 1'b0;
      ramwen_r   <= 1'b0;
      err_r      <= 1'b0;
      ramaddr_r  <= '0;
      ramstore_r <= '0;
      iload_r    <= '0;
      dload_r    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Both data strobes at once resolve to a write and flag the error.
          if (bus.dmemREN || bus.dmemWEN) begin
            state      <= DACC;
            ramaddr_r  <= bus.dmemaddr;
            ramstore_r <= bus.dmemstore;
            ramwen_r   <= bus.dmemWEN;
            ramren_r   <= !bus.dmemWEN;
            if (bus.dmemREN && bus.dmemWEN) err_r <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end else if (bus.imemREN) begin
            state     <= IACC;
            ramaddr_r <= bus.imemaddr;
            ramren_r  <= 1'b1;
            ramwen_r  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        DACC, IACC: begin
          if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
            state    <= RESP;
            ramren_r <= 1'b0;
            ramwen_r <= 1'b0;
            if (state == IACC) begin
              ihit_r  <= 1'b1;
              iload_r <= bus.ramload;
            end else begin
              dhit_r <= 1'b1;
              if (ramren_r) dload_r <= bus.ramload;
            end
            if (bus.ramstate == ERROR) err_r <= 1'b1;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state    <= RESP;
            ramren_r <= 1'b0;
            ramwen_r <= 1'b0;
            err_r    <= 1'b1;
            if (state == IACC) begin
              ihit_r  <= 1'b1;
              iload_r <= ARB_TIMEOUT_WORD;
            end else begin
              dhit_r  <= 1'b1;
              dload_r <= ARB_TIMEOUT_WORD;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          ihit_r <= 1'b0;
          dhit_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ihit     = ihit_r;
  assign bus.dhit     = dhit_r;
  assign bus.imemload = iload_r;
  assign bus.dmemload = dload_r;
  assign bus.ramREN   = ramren_r;
  assign bus.ramWEN   = ramwen_r;
  assign bus.ramaddr  = ramaddr_r;
  assign bus.ramstore = ramstore_r;
  assign bus.arb_err  = err_r;
  assign arb_state    = state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Responder end of the request-unit handshake. Accepts `imemREN`, `dmemREN` and `dmemWEN` strobes from the datapath request unit and arbitrates them onto a single RAM port. Returns one-cycle `ihit` and `dhit` pulses with registered load data. Sits between the request unit/datapath and the RAM model, replacing direct RAM wiring in the single-cycle and pipelined cores.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: watchdog limit per RAM access. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `imemREN` in 1: instruction read request.
- `imemaddr` in 32: instruction word address.
- `dmemREN` in 1: data read request.
- `dmemWEN` in 1: data write request.
- `dmemaddr` in 32: data address.
- `dmemstore` in 32: data write value.
- `ihit` out 1: one-cycle instruction completion pulse.
- `dhit` out 1: one-cycle data completion pulse, for reads and writes.
- `imemload` out 32: instruction word, valid while `ihit`.
- `dmemload` out 32: data word, valid while `dhit` for reads.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in `ramstate_t`: RAM status, one of FREE/BUSY/ACCESS/ERROR.
- `arb_err` out 1: sticky error flag (see Configuration).

## Operation
- FSM states:
  - IDLE: no grant.
  - DACC: data access in flight.
  - IACC: instruction access in flight.
  - RESP: hit cycle.
- IDLE:
  - `dmemREN|dmemWEN` → DACC. Data has priority over instruction.
  - Else `imemREN` → IACC.
  - Else stay in IDLE.
- On grant: latch address, store data, and direction into request registers. The RAM strobes are driven from these latched registers, never from live inputs.
- DACC/IACC:
  - Hold `ramREN` or `ramWEN` and `ramaddr`/`ramstore`.
  - When `ramstate==ACCESS`: capture `ramload` into the load register and go to RESP.
  - BUSY or FREE: stay.
- RESP:
  - Assert exactly one of `ihit`/`dhit` for one cycle. RAM strobes are low.
  - Next state is IDLE, unconditionally.
  - The requester drops or changes its strobe during RESP, so a stale request is never regranted.
- `dmemREN` and `dmemWEN` both high at grant: treated as a write. `arb_err` is set.
- A request withdrawn mid-access: the access still completes and the hit still pulses. The requester ignores the hit.
- `imemload`/`dmemload` hold their last captured value outside hit cycles.
- `ramstate==ERROR` during an access: the access completes as if ACCESS, with `ramload` captured as is, and `arb_err` is set.

## Timing
- Reset values:
  - State: IDLE.
  - `ihit`, `dhit`, `ramREN`, `ramWEN`, `arb_err`: 0.
  - `ramaddr`, `ramstore`, `imemload`, `dmemload`: 0.
- Reset mid-access: at the reset edge the FSM returns to IDLE, strobes drop, and no hit is issued.
- Latency: the request is sampled at edge 0 and the RAM strobe is high from edge 0. With ACCESS seen in cycle k, the hit is high in cycle k+1. Zero-wait RAM gives a 2-cycle request-to-hit time.
- Back-to-back requests: a gap of at least one IDLE cycle between hit and next grant (RESP→IDLE→grant). Throughput is at most one access per 3 cycles.
- `ihit` and `dhit` are never high in the same cycle.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit-minimum cycle counter runs in DACC/IACC and clears on grant.
  - When it reaches `TIMEOUT_CYCLES-1` without ACCESS: abort to RESP, pulse the hit with load data 32'hBAD0_BAD0, and set `arb_err`.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - The counter and logic are absent and the FSM waits indefinitely.
  - `arb_err` is still set by ERROR and by the dual-strobe condition.
- `arb_err` clears only on reset in both builds.

## Structure
- `cpu_types_pkg`:
  - Provides `word_t` and `ramstate_t`.
  - Add `arbstate_t` (IDLE/DACC/IACC/RESP) and `ARB_TIMEOUT_WORD` (32'hBAD0_BAD0).
- No sub-module; a single flat FSM plus request and load registers.

## Test plan
- Reset hold 3 cycles, then release with no requests → all outputs 0, state IDLE.
- `imemREN` with `imemaddr`=0x40, RAM 2 wait cycles then ACCESS with `ramload`=0x2002_0001 → `ramREN`=1, `ramaddr`=0x40 for 3 cycles; then `ihit` for 1 cycle with `imemload`=0x2002_0001.
- `imemREN` and `dmemWEN` together, `dmemaddr`=0x100, `dmemstore`=0xDEAD_BEEF → data wins: `ramWEN`, `ramaddr`=0x100. `dhit` comes first. The instruction is granted after RESP→IDLE and `ihit` follows.
- `dmemREN` and `dmemWEN` both high → a write is performed, `dhit` pulses, `arb_err`=1 and remains set.
- Reset asserted during DACC → at the next edge `ramWEN`/`ramREN`=0, no `dhit`, state IDLE.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, RAM held BUSY → `dhit` at cycle 9 with `dmemload`=0xBAD0_BAD0 and `arb_err`=1.
